alu_seq_ctrl: RTL

Multi-cycle sequencer that runs 8-bit operations on the team's 4-bit 74181-style ALU by issuing two nibble passes (low, then high) with the carry chained between them. Sits between a requesting datapath (start/op/operands) and one external combinational ALU instance, driving its operands, mode select, M and active-low carry-in. It returns an 8-bit result with carry and zero flags.

---
 rtl/alu_seq_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: 8-bit ops on an external 4-bit 74181-style ALU, low nibble pass then high, carry chained.
// Latency: 3 cycles start->done for legal ops, 1 cycle for illegal; start is ignored (not queued) while busy.
// ALU_SEQ_ACC_EN: op 111 becomes ACC (acc <= acc + opb) and the acc port is added.
module alu_seq_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [7:0] opa,
  input  logic [7:0] opb,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       carry,
  output logic       zero,
  output logic       err,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_s,
  output logic       alu_m,
  output logic       alu_ci_inverse,
  input  logic [3:0] alu_y,
  input  logic       alu_co_inverse
`ifdef ALU_SEQ_ACC_EN
  ,
  output logic [7:0] acc
`endif
);

`ifdef ALU_SEQ_ACC_EN
  localparam logic ACC_EN = 1'b1;
`else
  localparam logic ACC_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t     state_q, state_d;
  logic [2:0] op_q;
  logic [7:0] opa_q, opb_q;
  logic       lo_co_n_q;
  logic [3:0] dec_s;
  logic       dec_m, dec_arith, lo_ci_n;

  function automatic logic op_legal(input logic [2:0] o);
    op_legal = (o != 3'b111) || ACC_EN;
  endfunction

  // Op 111 decodes as ADD; it only reaches the ALU passes when the accumulator is built in.
  always_comb begin
    dec_s     = 4'b1001;
    dec_m     = 1'b0;
    dec_arith = 1'b1;
    case (op_q)
      3'b000: begin dec_s = 4'b1001; dec_m = 1'b0; dec_arith = 1'b1; end
      3'b001: begin dec_s = 4'b0110; dec_m = 1'b0; dec_arith = 1'b1; end
      3'b010: begin dec_s = 4'b1011; dec_m = 1'b1; dec_arith = 1'b0; end
      3'b011: begin dec_s = 4'b1110; dec_m = 1'b1; dec_arith = 1'b0; end
      3'b100: begin dec_s = 4'b0110; dec_m = 1'b1; dec_arith = 1'b0; end
      3'b101: begin dec_s = 4'b1111; dec_m = 1'b1; dec_arith = 1'b0; end
      3'b110: begin dec_s = 4'b0000; dec_m = 1'b1; dec_arith = 1'b0; end
      default: begin dec_s = 4'b1001; dec_m = 1'b0; dec_arith = 1'b1; end
    endcase
  end

  // SUB needs the forced carry-in for two's complement; everything else starts with no carry.
  assign lo_ci_n = (op_q != 3'b001);

  always_comb begin
    state_d        = state_q;
    alu_a          = 4'h0;
    alu_b          = 4'h0;
    alu_s          = 4'b0000;
    alu_m          = 1'b1;
    alu_ci_inverse = 1'b1;
    case (state_q)
      IDLE: if (start) state_d = op_legal(op) ? LO : DONE;
      LO: begin
        alu_a          = opa_q[3:0];
        alu_b          = opb_q[3:0];
        alu_s          = dec_s;
        alu_m          = dec_m;
        alu_ci_inverse = lo_ci_n;
        state_d        = HI;
      end
      HI: begin
        alu_a          = opa_q[7:4];
        alu_b          = opb_q[7:4];
        alu_s          = dec_s;
        alu_m          = dec_m;
        alu_ci_inverse = dec_arith ? lo_co_n_q : 1'b1;
        state_d        = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Flags are written on the edge entering DONE so they are valid alongside the done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q      <= 3'b000;
      opa_q     <= 8'h00;
      opb_q     <= 8'h00;
      lo_co_n_q <= 1'b1;
      result    <= 8'h00;
      carry     <= 1'b0;
      zero      <= 1'b0;
      err       <= 1'b0;
`ifdef ALU_SEQ_ACC_EN
      acc       <= 8'h00;
`endif
    end else begin
      case (state_q)
        IDLE: if (start) begin
          op_q  <= op;
          opb_q <= opb;
`ifdef ALU_SEQ_ACC_EN
          opa_q <= (op == 3'b111) ? acc : opa;
`else
          opa_q <= opa;
`endif
          if (!op_legal(op)) begin
            err  <= 1'b1;
            zero <= (result == 8'h00);
          end
        end
        LO: begin
          result[3:0] <= alu_y;
          lo_co_n_q   <= alu_co_inverse;
        end
        HI: begin
          result[7:4] <= alu_y;
          carry       <= dec_arith & ~alu_co_inverse;
          zero        <= ({alu_y, result[3:0]} == 8'h00);
          err         <= 1'b0;
`ifdef ALU_SEQ_ACC_EN
          if (op_q == 3'b111) acc <= {alu_y, result[3:0]};
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule
